// File: rtl/sdp_bram_pkg.sv
// Shared definitions for the simple dual-port byte-enable block RAM:
// read-mode encoding and the lane-merge helper used for write-first bypass.
package sdp_bram_pkg;

  typedef enum logic [1:0] {
    READ_FIRST  = 2'd0,
    WRITE_FIRST = 2'd1,
    NO_CHANGE   = 2'd2
  } rd_mode_e;

  // Widest word / lane count the merge helper handles; callers zero-extend.
  localparam int MAX_DBITS  = 256;
  localparam int MAX_BEBITS = 32;

  // Bit b of the result comes from new_word when the lane holding b
  // (lane index b / lw) has its enable set, otherwise from old_word.
  function automatic logic [MAX_DBITS-1:0] lane_merge(
    input logic [MAX_DBITS-1:0]  old_word,
    input logic [MAX_DBITS-1:0]  new_word,
    input logic [MAX_BEBITS-1:0] be,
    input int                    lw
  );
    logic [MAX_DBITS-1:0]  merged;
    logic [MAX_BEBITS-1:0] lane_sel;
    merged = old_word;
    for (int b = 0; b < MAX_DBITS; b++) begin
      lane_sel = be >> (b / lw);
      if (lane_sel[0]) merged[b] = new_word[b];
    end
    return merged;
  endfunction

endpackage

// File: rtl/sdp_bram_outreg.sv
// Data/valid pipeline register with an asynchronous reset value.
// The valid bit follows load every edge; data only moves when load is set,
// so the output holds its last value between accepted reads.
module sdp_bram_outreg #(
  parameter int             W       = 36,
  parameter logic [W-1:0]   RST_VAL = '0
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] d,
  output logic [W-1:0] q,
  output logic         q_valid
);

  // Capture data on load; valid tracks load; async reset to RST_VAL / invalid.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q       <= RST_VAL;
      q_valid <= 1'b0;
    end else begin
      q_valid <= load;
      if (load) q <= d;
    end
  end

endmodule

// File: rtl/sdp_bram_be.sv
// Simple dual-port block RAM with per-lane write enables, selectable
// collision behaviour (read-first / write-first / no-change) and an
// optional second output register stage.
module sdp_bram_be #(
  parameter int               ABITS   = 10,
  parameter int               DBITS   = 36,
  parameter int               BEBITS  = 4,
  parameter int               RD_MODE = 0,
  parameter int               OUT_REG = 0,
  parameter logic [DBITS-1:0] RST_VAL = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              we,
  input  logic [BEBITS-1:0] be,
  input  logic [ABITS-1:0]  wa,
  input  logic [DBITS-1:0]  wd,
  input  logic              re,
  input  logic [ABITS-1:0]  ra,
  output logic [DBITS-1:0]  rd,
  output logic              rd_valid
);
  import sdp_bram_pkg::*;

  localparam int       LW    = DBITS / BEBITS;
  localparam int       DEPTH = 2 ** ABITS;
  localparam rd_mode_e MODE  = rd_mode_e'(2'(RD_MODE));

  // Storage array: no reset so it maps onto block RAM.
  logic [DBITS-1:0] mem [DEPTH];

  logic                  wr_en;
  logic                  s1_load;
  logic [DBITS-1:0]      rd_word;
  logic [DBITS-1:0]      s1_d;
  logic [DBITS-1:0]      s1_q;
  logic                  s1_valid;
  logic [MAX_DBITS-1:0]  old_ext;
  logic [MAX_DBITS-1:0]  new_ext;
  logic [MAX_BEBITS-1:0] bypass_be;
  // Only the low DBITS bits are consumed; the rest are don't-care padding.
  logic [MAX_DBITS-1:0]  merged_wide_unused;

  assign wr_en = we && !rst;

  // In no-change mode any write cycle freezes the read pipeline input.
  assign s1_load = re && !((MODE == NO_CHANGE) && we);

  // Lane-gated write; lanes with be=0 keep their previous contents.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      for (int i = 0; i < BEBITS; i++) begin
        if (be[i]) mem[wa][i*LW +: LW] <= wd[i*LW +: LW];
      end
    end
  end

  // Stage-1 data select: raw array word, or on write-first collisions the
  // word with the enabled lanes replaced by the incoming write data.
  always_comb begin
    rd_word               = mem[ra];
    old_ext               = '0;
    old_ext[DBITS-1:0]    = rd_word;
    new_ext               = '0;
    new_ext[DBITS-1:0]    = wd;
    bypass_be             = '0;
    if (we && (ra == wa)) bypass_be[BEBITS-1:0] = be;
    merged_wide_unused    = lane_merge(old_ext, new_ext, bypass_be, LW);
    s1_d                  = rd_word;
    if (MODE == WRITE_FIRST) s1_d = merged_wide_unused[DBITS-1:0];
  end

  sdp_bram_outreg #(
    .W       (DBITS),
    .RST_VAL (RST_VAL)
  ) u_stage1 (
    .clk     (clk),
    .rst     (rst),
    .load    (s1_load),
    .d       (s1_d),
    .q       (s1_q),
    .q_valid (s1_valid)
  );

  generate
    if (OUT_REG != 0) begin : g_outreg
      sdp_bram_outreg #(
        .W       (DBITS),
        .RST_VAL (RST_VAL)
      ) u_stage2 (
        .clk     (clk),
        .rst     (rst),
        .load    (s1_valid),
        .d       (s1_q),
        .q       (rd),
        .q_valid (rd_valid)
      );
    end else begin : g_direct
      assign rd       = s1_q;
      assign rd_valid = s1_valid;
    end
  endgenerate

endmodule

// File: tb/tb_sdp_bram_be.sv
// Directed bench for sdp_bram_be: three single-stage instances (one per
// read mode) share a vector table; a registered-output instance with a
// non-zero reset value covers latency and mid-read reset.
module tb_sdp_bram_be;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        we  = 1'b0;
  logic [1:0]  be  = '0;
  logic [3:0]  wa  = '0;
  logic [15:0] wd  = '0;
  logic        re  = 1'b0;
  logic [3:0]  ra  = '0;

  logic [15:0] rd_rf, rd_wf, rd_nc, rd_or;
  logic        v_rf, v_wf, v_nc, v_or;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  sdp_bram_be #(.ABITS(4), .DBITS(16), .BEBITS(2), .RD_MODE(0), .OUT_REG(0), .RST_VAL(16'h0000)) u_rf (
    .clk(clk), .rst(rst), .we(we), .be(be), .wa(wa), .wd(wd),
    .re(re), .ra(ra), .rd(rd_rf), .rd_valid(v_rf));

  sdp_bram_be #(.ABITS(4), .DBITS(16), .BEBITS(2), .RD_MODE(1), .OUT_REG(0), .RST_VAL(16'h0000)) u_wf (
    .clk(clk), .rst(rst), .we(we), .be(be), .wa(wa), .wd(wd),
    .re(re), .ra(ra), .rd(rd_wf), .rd_valid(v_wf));

  sdp_bram_be #(.ABITS(4), .DBITS(16), .BEBITS(2), .RD_MODE(2), .OUT_REG(0), .RST_VAL(16'h0000)) u_nc (
    .clk(clk), .rst(rst), .we(we), .be(be), .wa(wa), .wd(wd),
    .re(re), .ra(ra), .rd(rd_nc), .rd_valid(v_nc));

  sdp_bram_be #(.ABITS(4), .DBITS(16), .BEBITS(2), .RD_MODE(0), .OUT_REG(1), .RST_VAL(16'h5A5A)) u_or (
    .clk(clk), .rst(rst), .we(we), .be(be), .wa(wa), .wd(wd),
    .re(re), .ra(ra), .rd(rd_or), .rd_valid(v_or));

  typedef struct {
    logic        we;
    logic [1:0]  be;
    logic [3:0]  wa;
    logic [15:0] wd;
    logic        re;
    logic [3:0]  ra;
    logic [15:0] rf_rd;
    logic        rf_v;
    logic [15:0] wf_rd;
    logic        wf_v;
    logic [15:0] nc_rd;
    logic        nc_v;
  } vec_t;

  vec_t vecs [15];

  function automatic vec_t mk(input logic w, input logic [1:0] b, input logic [3:0] a,
                              input logic [15:0] d, input logic r, input logic [3:0] ar,
                              input logic [15:0] erf, input logic vrf,
                              input logic [15:0] ewf, input logic vwf,
                              input logic [15:0] enc, input logic vnc);
    vec_t v;
    v.we = w; v.be = b; v.wa = a; v.wd = d; v.re = r; v.ra = ar;
    v.rf_rd = erf; v.rf_v = vrf; v.wf_rd = ewf; v.wf_v = vwf;
    v.nc_rd = enc; v.nc_v = vnc;
    return v;
  endfunction

  task automatic checkOutput(input string name, input logic [15:0] actual, input logic [15:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
    end
  endtask

  task automatic applyStimulus(input logic w, input logic [1:0] b, input logic [3:0] a,
                               input logic [15:0] d, input logic r, input logic [3:0] ar);
    we = w; be = b; wa = a; wd = d; re = r; ra = ar;
    @(posedge clk);
    #1;
  endtask

  initial begin
    // Columns: we be wa wd re ra | READ_FIRST rd,v | WRITE_FIRST rd,v | NO_CHANGE rd,v
    vecs[0]  = mk(1, 2'b11, 4'd3,  16'hBEEF, 0, 4'd0,  16'h0000, 0, 16'h0000, 0, 16'h0000, 0);
    vecs[1]  = mk(1, 2'b11, 4'd5,  16'h1234, 1, 4'd3,  16'hBEEF, 1, 16'hBEEF, 1, 16'h0000, 0);
    vecs[2]  = mk(1, 2'b11, 4'd7,  16'h0000, 0, 4'd0,  16'hBEEF, 0, 16'hBEEF, 0, 16'h0000, 0);
    vecs[3]  = mk(1, 2'b01, 4'd5,  16'hABCD, 0, 4'd0,  16'hBEEF, 0, 16'hBEEF, 0, 16'h0000, 0);
    vecs[4]  = mk(0, 2'b00, 4'd0,  16'h0000, 1, 4'd5,  16'h12CD, 1, 16'h12CD, 1, 16'h12CD, 1);
    vecs[5]  = mk(1, 2'b10, 4'd7,  16'hFF11, 1, 4'd7,  16'h0000, 1, 16'hFF00, 1, 16'h12CD, 0);
    vecs[6]  = mk(0, 2'b00, 4'd0,  16'h0000, 1, 4'd7,  16'hFF00, 1, 16'hFF00, 1, 16'hFF00, 1);
    vecs[7]  = mk(1, 2'b00, 4'd3,  16'h0000, 1, 4'd3,  16'hBEEF, 1, 16'hBEEF, 1, 16'hFF00, 0);
    vecs[8]  = mk(0, 2'b00, 4'd0,  16'h0000, 1, 4'd3,  16'hBEEF, 1, 16'hBEEF, 1, 16'hBEEF, 1);
    vecs[9]  = mk(1, 2'b11, 4'd15, 16'hC0DE, 1, 4'd5,  16'h12CD, 1, 16'h12CD, 1, 16'hBEEF, 0);
    vecs[10] = mk(0, 2'b00, 4'd0,  16'h0000, 1, 4'd15, 16'hC0DE, 1, 16'hC0DE, 1, 16'hC0DE, 1);
    vecs[11] = mk(1, 2'b11, 4'd0,  16'h0001, 0, 4'd0,  16'hC0DE, 0, 16'hC0DE, 0, 16'hC0DE, 0);
    vecs[12] = mk(0, 2'b00, 4'd0,  16'h0000, 1, 4'd15, 16'hC0DE, 1, 16'hC0DE, 1, 16'hC0DE, 1);
    vecs[13] = mk(0, 2'b00, 4'd0,  16'h0000, 1, 4'd0,  16'h0001, 1, 16'h0001, 1, 16'h0001, 1);
    vecs[14] = mk(0, 2'b00, 4'd0,  16'h0000, 0, 4'd0,  16'h0001, 0, 16'h0001, 0, 16'h0001, 0);

    #1 rst = 1'b1;
    #1;
    checkOutput("reset rf rd", rd_rf, 16'h0000);
    checkOutput("reset rf valid", {15'b0, v_rf}, 16'h0000);
    checkOutput("reset or rd", rd_or, 16'h5A5A);
    checkOutput("reset or valid", {15'b0, v_or}, 16'h0000);
    #1 rst = 1'b0;
    @(posedge clk);
    #1;

    for (int i = 0; i < 15; i++) begin
      applyStimulus(vecs[i].we, vecs[i].be, vecs[i].wa, vecs[i].wd, vecs[i].re, vecs[i].ra);
      checkOutput($sformatf("v%0d rf rd", i),    rd_rf,          vecs[i].rf_rd);
      checkOutput($sformatf("v%0d rf valid", i), {15'b0, v_rf},  {15'b0, vecs[i].rf_v});
      checkOutput($sformatf("v%0d wf rd", i),    rd_wf,          vecs[i].wf_rd);
      checkOutput($sformatf("v%0d wf valid", i), {15'b0, v_wf},  {15'b0, vecs[i].wf_v});
      checkOutput($sformatf("v%0d nc rd", i),    rd_nc,          vecs[i].nc_rd);
      checkOutput($sformatf("v%0d nc valid", i), {15'b0, v_nc},  {15'b0, vecs[i].nc_v});
    end

    // Two-stage latency: valid appears only after the second edge.
    applyStimulus(0, 2'b00, 4'd0, 16'h0000, 0, 4'd0);
    checkOutput("or idle valid", {15'b0, v_or}, 16'h0000);
    applyStimulus(0, 2'b00, 4'd0, 16'h0000, 1, 4'd3);
    checkOutput("or edge1 valid", {15'b0, v_or}, 16'h0000);
    applyStimulus(0, 2'b00, 4'd0, 16'h0000, 0, 4'd0);
    checkOutput("or edge2 rd", rd_or, 16'hBEEF);
    checkOutput("or edge2 valid", {15'b0, v_or}, 16'h0001);
    applyStimulus(0, 2'b00, 4'd0, 16'h0000, 0, 4'd0);
    checkOutput("or hold rd", rd_or, 16'hBEEF);
    checkOutput("or drop valid", {15'b0, v_or}, 16'h0000);

    // Reset pulse with a read in flight in the registered-output instance.
    applyStimulus(0, 2'b00, 4'd0, 16'h0000, 1, 4'd3);
    re = 1'b0;
    #1 rst = 1'b1;
    #1;
    checkOutput("midrst or rd", rd_or, 16'h5A5A);
    checkOutput("midrst or valid", {15'b0, v_or}, 16'h0000);
    checkOutput("midrst rf rd", rd_rf, 16'h0000);
    checkOutput("midrst rf valid", {15'b0, v_rf}, 16'h0000);
    // Held in reset across an edge: the write and read must both be ignored.
    applyStimulus(1, 2'b11, 4'd3, 16'h0000, 1, 4'd3);
    checkOutput("inrst or rd", rd_or, 16'h5A5A);
    checkOutput("inrst or valid", {15'b0, v_or}, 16'h0000);
    checkOutput("inrst rf valid", {15'b0, v_rf}, 16'h0000);
    we = 1'b0;
    re = 1'b0;
    rst = 1'b0;
    applyStimulus(0, 2'b00, 4'd0, 16'h0000, 0, 4'd0);
    checkOutput("postrst1 or valid", {15'b0, v_or}, 16'h0000);
    applyStimulus(0, 2'b00, 4'd0, 16'h0000, 0, 4'd0);
    checkOutput("postrst2 or valid", {15'b0, v_or}, 16'h0000);
    checkOutput("postrst2 or rd", rd_or, 16'h5A5A);
    applyStimulus(0, 2'b00, 4'd0, 16'h0000, 1, 4'd3);
    checkOutput("reread rf rd", rd_rf, 16'hBEEF);
    checkOutput("reread rf valid", {15'b0, v_rf}, 16'h0001);
    applyStimulus(0, 2'b00, 4'd0, 16'h0000, 0, 4'd0);
    checkOutput("reread or rd", rd_or, 16'hBEEF);
    checkOutput("reread or valid", {15'b0, v_or}, 16'h0001);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/sdp_bram_be.md
SDP_BRAM_BE -- requirements
Module: sdp_bram_be

Interface
REQ-001 SHALL have parameter ABITS, default 10, address width; depth = 2**ABITS words.
REQ-002 SHALL have parameter DBITS, default 36, data width.
REQ-003 SHALL have parameter BEBITS, default 4, byte-lane count; DBITS % BEBITS == 0, lane width LW = DBITS/BEBITS.
REQ-004 SHALL have parameter RD_MODE, default 0: 0 = READ_FIRST, 1 = WRITE_FIRST, 2 = NO_CHANGE.
REQ-005 SHALL have parameter OUT_REG, default 0: 0 = 1-cycle read latency, 1 = 2-cycle latency with an extra output register.
REQ-006 SHALL have parameter RST_VAL, default 0, DBITS wide, the reset value of rd.
REQ-007 clk  input  1  single clock; all state updates on posedge.
REQ-008 rst  input  1  asynchronous, active-high reset.
REQ-009 we  input  1  write enable.
REQ-010 be  input  BEBITS  per-lane write enable, qualified by we.
REQ-011 wa  input  ABITS  write address.
REQ-012 wd  input  DBITS  write data.
REQ-013 re  input  1  read enable.
REQ-014 ra  input  ABITS  read address.
REQ-015 rd  output  DBITS  registered read data.
REQ-016 rd_valid  output  1  high for exactly the cycle(s) rd carries data from an accepted read.

Function
REQ-017 A write SHALL occur on a posedge with we=1 and rst=0: lane i of mem[wa] gets wd lane i only when be[i]=1; other lanes are unchanged.
REQ-018 A read SHALL be accepted on a posedge with re=1 and rst=0; stage-1 data SHALL be latched that edge.
REQ-019 With OUT_REG=0, rd and rd_valid SHALL update at the accepting edge; with OUT_REG=1, they SHALL update one edge later.
REQ-020 When re=0, the stage-1 data register SHALL hold; rd_valid SHALL deassert at the corresponding output stage; rd SHALL hold its last value.
REQ-021 On collision (re, we, ra==wa, same edge), READ_FIRST SHALL return pre-write contents in all lanes.
REQ-022 On collision, WRITE_FIRST SHALL return wd in lanes with be=1 and old contents elsewhere.
REQ-023 In NO_CHANGE mode, any edge with we=1 SHALL leave the stage-1 register unchanged regardless of re or address, and that read SHALL NOT raise rd_valid.
REQ-024 Non-colliding simultaneous read and write SHALL be independent.
REQ-025 we=1 with be=0 SHALL write nothing but SHALL still count as a write for NO_CHANGE.
REQ-026 Address wrap SHALL NOT exist: every ABITS value maps to a distinct word, so the address range is exactly the depth.
REQ-027 Memory contents SHALL be uninitialised at start; a read of an unwritten word is unconstrained, and no check depends on it.

Reset
REQ-028 While rst=1, rd SHALL equal RST_VAL, rd_valid and all pipeline valid bits SHALL be 0, and the OUT_REG data stage SHALL equal RST_VAL, all asynchronously.
REQ-029 While rst=1, writes and reads SHALL be blocked.
REQ-030 Reset SHALL NOT clear memory contents; data written before reset SHALL be readable after it.
REQ-031 Reset asserted mid-read SHALL discard in-flight reads; no rd_valid SHALL appear for them after deassertion.

Structure
REQ-032 A shared package sdp_bram_pkg SHALL hold the RD_MODE enum (READ_FIRST, WRITE_FIRST, NO_CHANGE) and a lane-merge function (old, new, be) -> merged word.
REQ-033 One sub-module, sdp_bram_outreg (parametrised data/valid register with async reset value), SHALL implement both the stage-1 and optional stage-2 registers.
REQ-034 The storage array SHALL be inferable as block RAM: one write port, one read port, and no reset on the array.

Verification
REQ-035 Use ABITS=4, DBITS=16, BEBITS=2, OUT_REG=0. Write 0xBEEF to addr 3 with be=11, then read addr 3: rd=0xBEEF and rd_valid=1 on the next edge.
REQ-036 Byte enables: with mem[5]=0x1234, write 0xABCD with be=01, then read addr 5: rd=0x12CD.
REQ-037 Collision: with mem[7]=0x0000, same-edge we=1, be=10, wd=0xFF11, re=1, ra=wa=7:
- READ_FIRST gives rd=0x0000.
- WRITE_FIRST gives rd=0xFF00.
- NO_CHANGE keeps the previous rd, with rd_valid=0.
REQ-038 OUT_REG=1 latency: read addr 3 holding 0xBEEF -> rd_valid low after the first edge, rd=0xBEEF and rd_valid=1 after the second edge.
REQ-039 Reset mid-operation:
- RST_VAL=0x5A5A.
- Issue a read of addr 3 under OUT_REG=1, then pulse rst between edges.
- rd=0x5A5A and rd_valid=0 immediately; no rd_valid afterwards.
- A re-read of addr 3 returns 0xBEEF.
REQ-040 Formal gold/gate miter: for a random constant address, after the first write to it, rd SHALL match a behavioural gold model for every RD_MODE/OUT_REG combination.
